// File: rtl/cache_pkg.sv
// Shared encodings for the L1 request sequencer: sequencer states, request
// classification bit indices, block coherence states and snoop request /
// surrounding response codes.
package cache_pkg;

  typedef enum logic [2:0] {
    REQ_IDLE       = 3'd0,
    REQ_LOOKUP     = 3'd1,
    REQ_SDREQ      = 3'd2,
    REQ_WAIT_SURSP = 3'd3,
    REQ_RSP_CURSP  = 3'd4
  } req_st_e;

  // bit positions inside the one-hot req_status vector
  localparam int READ_HIT   = 0;
  localparam int WRITE_HIT  = 1;
  localparam int READ_MISS  = 2;
  localparam int WRITE_MISS = 3;

  // block coherence states
  localparam logic [2:0] INVALID   = 3'd0;
  localparam logic [2:0] SHARED    = 3'd1;
  localparam logic [2:0] EXCLUSIVE = 3'd2;
  localparam logic [2:0] MODIFIED  = 3'd3;

  // downstream snoop request opcodes
  localparam logic [2:0] SDREQ_NONE = 3'd0;
  localparam logic [2:0] SDREQ_RD   = 3'd1;
  localparam logic [2:0] SDREQ_RFO  = 3'd2;
  localparam logic [2:0] SDREQ_INV  = 3'd3;

  // surrounding response codes
  localparam logic [2:0] SURSP_NONE  = 3'd0;
  localparam logic [2:0] SURSP_FETCH = 3'd1;
  localparam logic [2:0] SURSP_SNOOP = 3'd2;
  localparam logic [2:0] SURSP_ACK   = 3'd3;

endpackage

// File: rtl/l1_req_seq_if.sv
// Bus bundle around the L1 request sequencer.
//   CPU request/response : cdreq_* (in), cursp_* (out)
//   tag/state array      : tag_rd_* (out), tag_hit/tag_st (in), blk_* (out)
//   snoop side           : sdreq_* (out), sursp_* (in)
//   status observation   : req_status, req_curSt, blk_curSt, sursp_rsp (out)
// master = environment (CPU, array, interconnect); slave = l1_req_seq.
interface l1_req_seq_if #(
  parameter int ADDR_W = 32
);
  logic              cdreq_valid;
  logic              cdreq_ready;
  logic              cdreq_wr;
  logic [ADDR_W-1:0] cdreq_addr;

  logic              tag_rd_en;
  logic [ADDR_W-1:0] tag_rd_addr;
  logic              tag_hit;
  logic [2:0]        tag_st;

  logic              blk_we;
  logic [ADDR_W-1:0] blk_wr_addr;
  logic [2:0]        blk_wr_st;

  logic              sdreq_valid;
  logic              sdreq_ready;
  logic [2:0]        sdreq_op;
  logic [ADDR_W-1:0] sdreq_addr;

  logic              sursp_valid;
  logic [2:0]        sursp_rsp_in;

  logic              cursp_valid;
  logic              cursp_ready;
  logic              cursp_err;

  logic [3:0]        req_status;
  logic [2:0]        req_curSt;
  logic [2:0]        blk_curSt;
  logic [2:0]        sursp_rsp;

  modport master (
    output cdreq_valid, cdreq_wr, cdreq_addr, tag_hit, tag_st,
           sdreq_ready, sursp_valid, sursp_rsp_in, cursp_ready,
    input  cdreq_ready, tag_rd_en, tag_rd_addr, blk_we, blk_wr_addr, blk_wr_st,
           sdreq_valid, sdreq_op, sdreq_addr, cursp_valid, cursp_err,
           req_status, req_curSt, blk_curSt, sursp_rsp
  );

  modport slave (
    input  cdreq_valid, cdreq_wr, cdreq_addr, tag_hit, tag_st,
           sdreq_ready, sursp_valid, sursp_rsp_in, cursp_ready,
    output cdreq_ready, tag_rd_en, tag_rd_addr, blk_we, blk_wr_addr, blk_wr_st,
           sdreq_valid, sdreq_op, sdreq_addr, cursp_valid, cursp_err,
           req_status, req_curSt, blk_curSt, sursp_rsp
  );
endinterface

// File: rtl/l1_req_seq_ctrl.sv
// Coherence decision table for the request sequencer (purely combinational).
//   in : req_status (one-hot class), req_curSt, blk_curSt, sursp_rsp
//   out: init_sdreq (snoop opcode while in SDREQ),
//        blk_nxtSt  (state to commit while in RSP_CURSP)
module fsm_l1_req_ctrl
  import cache_pkg::*;
(
  input  logic [3:0] req_status,
  input  logic [2:0] req_curSt,
  input  logic [2:0] blk_curSt,
  input  logic [2:0] sursp_rsp,
  output logic [2:0] blk_nxtSt,
  output logic [2:0] init_sdreq
);

  always_comb begin
    init_sdreq = SDREQ_NONE;
    blk_nxtSt  = blk_curSt;

    if (req_curSt == REQ_SDREQ) begin
      if (req_status[READ_MISS])       init_sdreq = SDREQ_RD;
      else if (req_status[WRITE_MISS]) init_sdreq = SDREQ_RFO;
      else if (req_status[WRITE_HIT])  init_sdreq = SDREQ_INV;
    end

    // read hits keep their current state
    if (req_curSt == REQ_RSP_CURSP) begin
      if (req_status[WRITE_HIT] || req_status[WRITE_MISS]) begin
        blk_nxtSt = MODIFIED;
      end else if (req_status[READ_MISS]) begin
        // another cache holding the line forces SHARED, otherwise we own it
        blk_nxtSt = (sursp_rsp == SURSP_SNOOP) ? SHARED : EXCLUSIVE;
      end
    end
  end

endmodule

// File: rtl/l1_req_seq.sv
// CPU-side request sequencer for one L1 cache: accept, tag lookup, optional
// snoop with response timeout, state commit and CPU response.
//   clk, rst_n : clock and async active-low reset
//   bus        : l1_req_seq_if.slave (CPU, tag array, snoop and status signals)
//
// state          | meaning
// REQ_IDLE       | ready for a CPU request
// REQ_LOOKUP     | tag read issued (1st cycle), classify on returned data (2nd)
// REQ_SDREQ      | snoop request held on sdreq_* until accepted
// REQ_WAIT_SURSP | waiting for surrounding response, timer running
// REQ_RSP_CURSP  | CPU response held until accepted, state write on handshake
module l1_req_seq
  import cache_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int TO_CYC = 64
) (
  input logic         clk,
  input logic         rst_n,
  l1_req_seq_if.slave bus
);

  localparam int              TMR_W    = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TO_CYC - 1);

  req_st_e           state_q, state_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              tag_rd_q, tag_rd_d;
  logic [3:0]        status_q, status_d;
  logic [2:0]        blk_cur_q, blk_cur_d;
  logic [2:0]        sursp_q, sursp_d;
  logic [2:0]        wr_st_q, wr_st_d;
  logic              blk_we_q, blk_we_d;
  logic              err_q, err_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;

  logic              hit;
  logic [2:0]        blk_nxt;
  logic [2:0]        init_sd;

  fsm_l1_req_ctrl u_ctrl (
    .req_status (status_q),
    .req_curSt  (state_q),
    .blk_curSt  (blk_cur_q),
    .sursp_rsp  (sursp_q),
    .blk_nxtSt  (blk_nxt),
    .init_sdreq (init_sd)
  );

  always_comb begin
    state_d   = state_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    tag_rd_d  = 1'b0;
    status_d  = status_q;
    blk_cur_d = blk_cur_q;
    sursp_d   = sursp_q;
    wr_st_d   = wr_st_q;
    blk_we_d  = 1'b0;
    err_d     = err_q;
    tmr_d     = tmr_q;
    hit       = bus.tag_hit && (bus.tag_st != INVALID);

    case (state_q)
      REQ_IDLE: begin
        if (bus.cdreq_valid) begin
          wr_d     = bus.cdreq_wr;
          addr_d   = bus.cdreq_addr;
          tag_rd_d = 1'b1;
          state_d  = REQ_LOOKUP;
        end
      end

      REQ_LOOKUP: begin
        // array data is only valid in the cycle after the read strobe
        if (!tag_rd_q) begin
          blk_cur_d = hit ? bus.tag_st : INVALID;
          status_d  = '0;
          case ({wr_q, hit})
            2'b01:   status_d[READ_HIT]   = 1'b1;
            2'b11:   status_d[WRITE_HIT]  = 1'b1;
            2'b00:   status_d[READ_MISS]  = 1'b1;
            default: status_d[WRITE_MISS] = 1'b1;
          endcase
          if (hit && (!wr_q || bus.tag_st == EXCLUSIVE || bus.tag_st == MODIFIED)) begin
            state_d = REQ_RSP_CURSP;
          end else begin
            state_d = REQ_SDREQ;
          end
        end
      end

      REQ_SDREQ: begin
        if (bus.sdreq_ready) begin
          tmr_d   = '0;
          state_d = REQ_WAIT_SURSP;
        end
      end

      REQ_WAIT_SURSP: begin
        if (tmr_q != TMR_LAST) tmr_d = tmr_q + 1'b1;
        // a response arriving on the expiry cycle still counts
        if (bus.sursp_valid) begin
          sursp_d = bus.sursp_rsp_in;
          state_d = REQ_RSP_CURSP;
        end else if (tmr_q == TMR_LAST) begin
          err_d   = 1'b1;
          sursp_d = SURSP_NONE;
          state_d = REQ_RSP_CURSP;
        end
      end

      REQ_RSP_CURSP: begin
        if (bus.cursp_ready) begin
          blk_we_d = !err_q;
          wr_st_d  = blk_nxt;
          status_d = '0;
          err_d    = 1'b0;
          sursp_d  = SURSP_NONE;
          state_d  = REQ_IDLE;
        end
      end

      default: state_d = REQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= REQ_IDLE;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      tag_rd_q  <= 1'b0;
      status_q  <= '0;
      blk_cur_q <= INVALID;
      sursp_q   <= SURSP_NONE;
      wr_st_q   <= INVALID;
      blk_we_q  <= 1'b0;
      err_q     <= 1'b0;
      tmr_q     <= '0;
    end else begin
      state_q   <= state_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      tag_rd_q  <= tag_rd_d;
      status_q  <= status_d;
      blk_cur_q <= blk_cur_d;
      sursp_q   <= sursp_d;
      wr_st_q   <= wr_st_d;
      blk_we_q  <= blk_we_d;
      err_q     <= err_d;
      tmr_q     <= tmr_d;
    end
  end

  // The state write is registered, so it appears in the cycle after the
  // cursp handshake; addr_q is still the committed address in that cycle.
  assign bus.cdreq_ready = (state_q == REQ_IDLE);
  assign bus.tag_rd_en   = tag_rd_q;
  assign bus.tag_rd_addr = addr_q;
  assign bus.blk_we      = blk_we_q;
  assign bus.blk_wr_addr = addr_q;
  assign bus.blk_wr_st   = wr_st_q;
  assign bus.sdreq_valid = (state_q == REQ_SDREQ);
  assign bus.sdreq_op    = init_sd;
  assign bus.sdreq_addr  = addr_q;
  assign bus.cursp_valid = (state_q == REQ_RSP_CURSP);
  assign bus.cursp_err   = err_q;
  assign bus.req_status  = status_q;
  assign bus.req_curSt   = state_q;
  assign bus.blk_curSt   = blk_cur_q;
  assign bus.sursp_rsp   = sursp_q;

endmodule

// File: tb/tb_l1_req_seq.sv
module tb_l1_req_seq;
  import cache_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  l1_req_seq_if #(.ADDR_W(32)) bus ();

  l1_req_seq #(.ADDR_W(32), .TO_CYC(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input logic wr, input logic [31:0] addr,
                           input logic hit, input logic [2:0] st);
    bus.tag_hit     = hit;
    bus.tag_st      = st;
    bus.cdreq_wr    = wr;
    bus.cdreq_addr  = addr;
    bus.cdreq_valid = 1'b1;
    step();
    bus.cdreq_valid = 1'b0;
  endtask

  task automatic finish_rsp();
    bus.cursp_ready = 1'b1;
    step();
    bus.cursp_ready = 1'b0;
  endtask

  task automatic wait_sdreq(output int n);
    n = 0;
    while (!bus.sdreq_valid && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic wait_cursp(output int n, output logic saw_sd);
    n = 0;
    saw_sd = 1'b0;
    while (!bus.cursp_valid && n < 40) begin
      if (bus.sdreq_valid) saw_sd = 1'b1;
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    bus.cdreq_valid = 0; bus.cdreq_wr = 0; bus.cdreq_addr = '0;
    bus.tag_hit = 0; bus.tag_st = INVALID; bus.sdreq_ready = 0;
    bus.sursp_valid = 0; bus.sursp_rsp_in = SURSP_NONE; bus.cursp_ready = 0;
    #3;
    checks++;
    if (bus.cdreq_ready !== 1'b1) begin
      $display("FAIL rst_cdreq_ready got %b want 1", bus.cdreq_ready); errors++;
    end
    checks++;
    if ({bus.tag_rd_en, bus.blk_we, bus.sdreq_valid, bus.cursp_valid, bus.cursp_err} !== 5'b0) begin
      $display("FAIL rst_strobes got %b want 00000",
               {bus.tag_rd_en, bus.blk_we, bus.sdreq_valid, bus.cursp_valid, bus.cursp_err});
      errors++;
    end
    checks++;
    if ({bus.req_status, bus.req_curSt, bus.blk_curSt, bus.sursp_rsp, bus.sdreq_op} !== 16'h0) begin
      $display("FAIL rst_status got %h want 0000",
               {bus.req_status, bus.req_curSt, bus.blk_curSt, bus.sursp_rsp, bus.sdreq_op});
      errors++;
    end
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_read_hit();
    int n;
    logic saw;
    start_req(1'b0, 32'h0000_1040, 1'b1, SHARED);
    checks++;
    if (bus.tag_rd_en !== 1'b1 || bus.tag_rd_addr !== 32'h0000_1040) begin
      $display("FAIL rh_tag_rd got en=%b addr=%h want en=1 addr=00001040", bus.tag_rd_en, bus.tag_rd_addr);
      errors++;
    end
    checks++;
    if (bus.cdreq_ready !== 1'b0) begin
      $display("FAIL rh_busy_ready got %b want 0", bus.cdreq_ready); errors++;
    end
    wait_cursp(n, saw);
    checks++;
    if (n !== 2) begin
      $display("FAIL rh_latency got %0d want 2", n); errors++;
    end
    checks++;
    if (bus.req_status !== 4'b0001 || bus.blk_curSt !== SHARED || saw !== 1'b0) begin
      $display("FAIL rh_class got status=%b blk=%0d sdreq_seen=%b want 0001 1 0",
               bus.req_status, bus.blk_curSt, saw);
      errors++;
    end
    finish_rsp();
    checks++;
    if (bus.blk_we !== 1'b1 || bus.blk_wr_st !== SHARED || bus.blk_wr_addr !== 32'h0000_1040) begin
      $display("FAIL rh_commit got we=%b st=%0d addr=%h want 1 1 00001040",
               bus.blk_we, bus.blk_wr_st, bus.blk_wr_addr);
      errors++;
    end
    checks++;
    if (bus.req_status !== 4'b0 || bus.cdreq_ready !== 1'b1) begin
      $display("FAIL rh_return got status=%b ready=%b want 0000 1", bus.req_status, bus.cdreq_ready);
      errors++;
    end
    step();
    checks++;
    if (bus.blk_we !== 1'b0) begin
      $display("FAIL rh_we_pulse got %b want 0", bus.blk_we); errors++;
    end
  endtask

  task automatic test_write_hit_shared();
    int n;
    start_req(1'b1, 32'h0000_2080, 1'b1, SHARED);
    wait_sdreq(n);
    checks++;
    if (n !== 2 || bus.sdreq_op !== SDREQ_INV || bus.sdreq_addr !== 32'h0000_2080) begin
      $display("FAIL whs_sdreq got n=%0d op=%0d addr=%h want 2 3 00002080", n, bus.sdreq_op, bus.sdreq_addr);
      errors++;
    end
    checks++;
    if (bus.req_status !== 4'b0010) begin
      $display("FAIL whs_status got %b want 0010", bus.req_status); errors++;
    end
    bus.sdreq_ready = 1'b1;
    step();
    bus.sdreq_ready = 1'b0;
    bus.sursp_valid = 1'b1;
    bus.sursp_rsp_in = SURSP_ACK;
    step();
    bus.sursp_valid = 1'b0;
    checks++;
    if (bus.cursp_valid !== 1'b1 || bus.sursp_rsp !== SURSP_ACK) begin
      $display("FAIL whs_latency4 got cursp=%b rsp=%0d want 1 3", bus.cursp_valid, bus.sursp_rsp);
      errors++;
    end
    finish_rsp();
    checks++;
    if (bus.blk_we !== 1'b1 || bus.blk_wr_st !== MODIFIED) begin
      $display("FAIL whs_commit got we=%b st=%0d want 1 3", bus.blk_we, bus.blk_wr_st); errors++;
    end
  endtask

  task automatic test_read_miss();
    logic [2:0] rsp_v [2];
    logic [2:0] st_v  [2];
    logic       hit_v [2];
    logic [31:0] a;
    int n;
    rsp_v[0] = SURSP_FETCH; st_v[0] = EXCLUSIVE; hit_v[0] = 1'b0;
    rsp_v[1] = SURSP_SNOOP; st_v[1] = SHARED;    hit_v[1] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      a = 32'h0000_3000 + 32'(i) * 32'h40;
      // second pass: tag matches but line is INVALID, still a miss
      start_req(1'b0, a, hit_v[i], hit_v[i] ? INVALID : SHARED);
      wait_sdreq(n);
      checks++;
      if (n !== 2 || bus.sdreq_op !== SDREQ_RD || bus.req_status !== 4'b0100 || bus.blk_curSt !== INVALID) begin
        $display("FAIL rm%0d_sdreq got n=%0d op=%0d status=%b blk=%0d want 2 1 0100 0",
                 i, n, bus.sdreq_op, bus.req_status, bus.blk_curSt);
        errors++;
      end
      bus.sdreq_ready = 1'b1;
      step();
      bus.sdreq_ready = 1'b0;
      bus.sursp_valid = 1'b1;
      bus.sursp_rsp_in = rsp_v[i];
      step();
      bus.sursp_valid = 1'b0;
      checks++;
      if (bus.cursp_valid !== 1'b1 || bus.cursp_err !== 1'b0) begin
        $display("FAIL rm%0d_rsp got cursp=%b err=%b want 1 0", i, bus.cursp_valid, bus.cursp_err);
        errors++;
      end
      finish_rsp();
      checks++;
      if (bus.blk_we !== 1'b1 || bus.blk_wr_st !== st_v[i] || bus.blk_wr_addr !== a) begin
        $display("FAIL rm%0d_commit got we=%b st=%0d addr=%h want 1 %0d %h",
                 i, bus.blk_we, bus.blk_wr_st, bus.blk_wr_addr, st_v[i], a);
        errors++;
      end
    end
  endtask

  task automatic test_write_miss_stall();
    int n;
    logic [2:0] op0;
    logic [31:0] a0;
    logic stable;
    start_req(1'b1, 32'h0000_4100, 1'b0, INVALID);
    wait_sdreq(n);
    op0 = bus.sdreq_op;
    a0 = bus.sdreq_addr;
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      // a stray response while the snoop is not yet accepted must be ignored
      bus.sursp_valid = (i == 2);
      bus.sursp_rsp_in = SURSP_SNOOP;
      step();
      if (bus.sdreq_valid !== 1'b1 || bus.sdreq_op !== op0 || bus.sdreq_addr !== a0 ||
          bus.req_curSt !== 3'd2) stable = 1'b0;
    end
    bus.sursp_valid = 1'b0;
    checks++;
    if (n !== 2 || op0 !== SDREQ_RFO || a0 !== 32'h0000_4100 || bus.req_status !== 4'b1000) begin
      $display("FAIL wm_sdreq got n=%0d op=%0d addr=%h status=%b want 2 2 00004100 1000",
               n, op0, a0, bus.req_status);
      errors++;
    end
    checks++;
    if (stable !== 1'b1 || bus.sursp_rsp !== SURSP_NONE) begin
      $display("FAIL wm_stall_stable got stable=%b rsp=%0d want 1 0", stable, bus.sursp_rsp);
      errors++;
    end
    bus.sdreq_ready = 1'b1;
    step();
    bus.sdreq_ready = 1'b0;
    checks++;
    if (bus.req_curSt !== 3'd3 || bus.sdreq_valid !== 1'b0) begin
      $display("FAIL wm_wait got st=%0d sdreq=%b want 3 0", bus.req_curSt, bus.sdreq_valid);
      errors++;
    end
    repeat (2) step();
    bus.sursp_valid = 1'b1;
    bus.sursp_rsp_in = SURSP_FETCH;
    step();
    bus.sursp_valid = 1'b0;
    checks++;
    if (bus.cursp_valid !== 1'b1 || bus.sursp_rsp !== SURSP_FETCH) begin
      $display("FAIL wm_rsp got cursp=%b rsp=%0d want 1 1", bus.cursp_valid, bus.sursp_rsp);
      errors++;
    end
    finish_rsp();
    checks++;
    if (bus.blk_we !== 1'b1 || bus.blk_wr_st !== MODIFIED) begin
      $display("FAIL wm_commit got we=%b st=%0d want 1 3", bus.blk_we, bus.blk_wr_st); errors++;
    end
  endtask

  task automatic test_timeout();
    int n;
    logic saw;
    start_req(1'b0, 32'h0000_5000, 1'b0, INVALID);
    wait_sdreq(n);
    bus.sdreq_ready = 1'b1;
    step();
    bus.sdreq_ready = 1'b0;
    // TO_CYC=8: eight WAIT cycles (timer 0..7) before expiry
    wait_cursp(n, saw);
    checks++;
    if (n !== 8) begin
      $display("FAIL to_cycles got %0d want 8", n); errors++;
    end
    checks++;
    if (bus.cursp_err !== 1'b1 || bus.sursp_rsp !== SURSP_NONE) begin
      $display("FAIL to_err got err=%b rsp=%0d want 1 0", bus.cursp_err, bus.sursp_rsp); errors++;
    end
    finish_rsp();
    checks++;
    if (bus.blk_we !== 1'b0 || bus.cursp_err !== 1'b0) begin
      $display("FAIL to_no_write got we=%b err=%b want 0 0", bus.blk_we, bus.cursp_err); errors++;
    end

    start_req(1'b0, 32'h0000_5040, 1'b0, INVALID);
    wait_sdreq(n);
    bus.sdreq_ready = 1'b1;
    step();
    bus.sdreq_ready = 1'b0;
    repeat (7) step();
    checks++;
    if (bus.req_curSt !== 3'd3) begin
      $display("FAIL to_edge_wait got st=%0d want 3", bus.req_curSt); errors++;
    end
    bus.sursp_valid = 1'b1;
    bus.sursp_rsp_in = SURSP_SNOOP;
    step();
    bus.sursp_valid = 1'b0;
    checks++;
    if (bus.cursp_valid !== 1'b1 || bus.cursp_err !== 1'b0 || bus.sursp_rsp !== SURSP_SNOOP) begin
      $display("FAIL to_edge_rsp got cursp=%b err=%b rsp=%0d want 1 0 2",
               bus.cursp_valid, bus.cursp_err, bus.sursp_rsp);
      errors++;
    end
    finish_rsp();
    checks++;
    if (bus.blk_we !== 1'b1 || bus.blk_wr_st !== SHARED) begin
      $display("FAIL to_edge_commit got we=%b st=%0d want 1 1", bus.blk_we, bus.blk_wr_st); errors++;
    end
  endtask

  task automatic test_reset_mid();
    int n;
    logic saw;
    start_req(1'b1, 32'h0000_6000, 1'b0, INVALID);
    wait_sdreq(n);
    bus.sdreq_ready = 1'b1;
    step();
    bus.sdreq_ready = 1'b0;
    repeat (2) step();
    rst_n = 1'b0;
    #2;
    checks++;
    if (bus.req_curSt !== 3'd0 || bus.cdreq_ready !== 1'b1 || bus.req_status !== 4'b0 ||
        bus.blk_curSt !== INVALID || bus.sdreq_addr !== 32'h0) begin
      $display("FAIL mrst_state got st=%0d ready=%b status=%b blk=%0d addr=%h want 0 1 0000 0 0",
               bus.req_curSt, bus.cdreq_ready, bus.req_status, bus.blk_curSt, bus.sdreq_addr);
      errors++;
    end
    step();
    rst_n = 1'b1;
    step();
    start_req(1'b0, 32'h0000_6040, 1'b1, EXCLUSIVE);
    wait_cursp(n, saw);
    checks++;
    if (n !== 2 || saw !== 1'b0 || bus.req_status !== 4'b0001) begin
      $display("FAIL mrst_new_req got n=%0d sdreq_seen=%b status=%b want 2 0 0001", n, saw, bus.req_status);
      errors++;
    end
    finish_rsp();
    checks++;
    if (bus.blk_we !== 1'b1 || bus.blk_wr_st !== EXCLUSIVE || bus.blk_wr_addr !== 32'h0000_6040) begin
      $display("FAIL mrst_commit got we=%b st=%0d addr=%h want 1 2 00006040",
               bus.blk_we, bus.blk_wr_st, bus.blk_wr_addr);
      errors++;
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic saw;
    start_req(1'b1, 32'h0000_7000, 1'b1, MODIFIED);
    wait_cursp(n, saw);
    checks++;
    if (n !== 2 || saw !== 1'b0 || bus.req_status !== 4'b0010) begin
      $display("FAIL b2b_first got n=%0d sdreq_seen=%b status=%b want 2 0 0010", n, saw, bus.req_status);
      errors++;
    end
    finish_rsp();
    checks++;
    if (bus.blk_we !== 1'b1 || bus.blk_wr_st !== MODIFIED || bus.blk_wr_addr !== 32'h0000_7000 ||
        bus.cdreq_ready !== 1'b1) begin
      $display("FAIL b2b_first_commit got we=%b st=%0d addr=%h ready=%b want 1 3 00007000 1",
               bus.blk_we, bus.blk_wr_st, bus.blk_wr_addr, bus.cdreq_ready);
      errors++;
    end
    start_req(1'b0, 32'h0000_7040, 1'b1, EXCLUSIVE);
    checks++;
    if (bus.tag_rd_en !== 1'b1 || bus.tag_rd_addr !== 32'h0000_7040 || bus.blk_we !== 1'b0) begin
      $display("FAIL b2b_accept got en=%b addr=%h we=%b want 1 00007040 0",
               bus.tag_rd_en, bus.tag_rd_addr, bus.blk_we);
      errors++;
    end
    wait_cursp(n, saw);
    checks++;
    if (n !== 2 || bus.req_status !== 4'b0001) begin
      $display("FAIL b2b_second got n=%0d status=%b want 2 0001", n, bus.req_status); errors++;
    end
    finish_rsp();
    checks++;
    if (bus.blk_we !== 1'b1 || bus.blk_wr_st !== EXCLUSIVE) begin
      $display("FAIL b2b_second_commit got we=%b st=%0d want 1 2", bus.blk_we, bus.blk_wr_st); errors++;
    end
  endtask

  initial begin
    test_reset();
    test_read_hit();
    test_write_hit_shared();
    test_read_miss();
    test_write_miss_stall();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    repeat (2) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
